// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin selection function for the packet arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int MAX_PORTS = 16;

  // First requester strictly after 'last' in circular order over num_ports.
  function automatic int unsigned rr_next(input logic [MAX_PORTS-1:0] req,
                                          input int unsigned last,
                                          input int unsigned num_ports);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
      idx = (last + k) % num_ports;
      if (!found && k <= num_ports && req[idx[3:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer; in_ready depends only on occupancy, never on out_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: the storage is reset as well because its contents drive m_* directly and must read zero out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= in_data;
          else                 tail_q <= in_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI-Stream packet arbiter, one grant held per packet.
// Define AXIS_PACKET_ARBITER_OUT_REG_EN to register m_* through a 2-entry skid buffer.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_WIDTH  = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic [ID_WIDTH-1:0]             m_tid,
  output logic [15:0]                     pkt_count
);

  arb_state_t            state;
  logic [ID_WIDTH-1:0]   grant_q;
  logic [ID_WIDTH-1:0]   last_grant;
  logic [15:0]           pkt_q;
  logic [MAX_PORTS-1:0]  req;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  beat_xfer;

  assign sel_valid = s_tvalid[grant_q];
  assign sel_last  = s_tlast[grant_q];
  assign sel_data  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign beat_xfer = (state == LOCKED) && sel_valid && sel_ready;
  assign pkt_count = pkt_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req = '0;
    req[NUM_PORTS-1:0] = s_tvalid;
  end

  always_comb begin
    s_tready = '0;
    if (state == LOCKED) s_tready[grant_q] = sel_ready;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= ID_WIDTH'(NUM_PORTS - 1);
      pkt_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_tvalid) begin
            grant_q <= ID_WIDTH'(rr_next(req, 32'(last_grant), 32'(NUM_PORTS)));
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (beat_xfer && sel_last) begin
            state      <= IDLE;
            last_grant <= grant_q;
            pkt_q      <= pkt_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_PACKET_ARBITER_OUT_REG_EN
  logic buf_ready;

  axis_skid_buffer #(
    .WIDTH(ID_WIDTH + 1 + DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   ({grant_q, sel_last, sel_data}),
    .in_valid  ((state == LOCKED) && sel_valid),
    .in_ready  (buf_ready),
    .out_data  ({m_tid, m_tlast, m_tdata}),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

  assign sel_ready = buf_ready;
`else
  assign sel_ready = m_tready;
  assign m_tvalid  = (state == LOCKED) && sel_valid;
  assign m_tlast   = (state == LOCKED) && sel_last;
  assign m_tdata   = (state == LOCKED) ? sel_data : '0;
  assign m_tid     = grant_q;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-cycle comparison against a packet-level model plus literal checks.
module tb_axis_packet_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]   s_tvalid;
  logic [NP-1:0]   s_tlast;
  logic [NP-1:0]   s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic [IW-1:0]   m_tid;
  logic [15:0]     pkt_count;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .m_tid     (m_tid),
    .pkt_count (pkt_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            tid;
    logic [DW-1:0] data;
    bit            last;
    int            cyc;
  } obs_t;

  beat_t   src_q[NP][$];
  logic [NP-1:0] src_hold = '0;
  logic [NP-1:0] hs = '0;
  obs_t    out_log[$];
  int      cyc = 0;

  // Packet-level model: idle/locked, who holds the grant, who last finished, packets done.
  bit            md_locked, nx_locked;
  logic [IW-1:0] md_grant, nx_grant, md_last, nx_last;
  logic [15:0]   md_cnt, nx_cnt;

  always @(posedge clk) begin
    cyc++;
    md_locked = nx_locked;
    md_grant  = nx_grant;
    md_last   = nx_last;
    md_cnt    = nx_cnt;
  end

  always @(negedge clk) begin
    logic [NP-1:0] exp_ready;
    logic [IW-1:0] idx;
    bit            found;
    if (!resetn) begin
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tid", m_tid, 0);
      check("rst_pkt_count", pkt_count, 0);
      nx_locked = 1'b0;
      nx_grant  = '0;
      nx_last   = IW'(NP - 1);
      nx_cnt    = '0;
      hs        = '0;
    end else begin
      exp_ready = '0;
      if (md_locked) exp_ready[md_grant] = m_tready;
      check("s_tready", s_tready, exp_ready);
      check("m_tvalid", m_tvalid, md_locked && s_tvalid[md_grant]);
      if (md_locked && s_tvalid[md_grant]) begin
        check("m_tdata", m_tdata, s_tdata[md_grant*DW +: DW]);
        check("m_tlast", m_tlast, s_tlast[md_grant]);
        check("m_tid", m_tid, md_grant);
      end
      check("pkt_count", pkt_count, md_cnt);
      nx_locked = md_locked;
      nx_grant  = md_grant;
      nx_last   = md_last;
      nx_cnt    = md_cnt;
      if (!md_locked) begin
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          idx = IW'((int'(md_last) + k) % NP);
          if (!found && s_tvalid[idx]) begin
            found    = 1'b1;
            nx_grant = idx;
          end
        end
        if (found) nx_locked = 1'b1;
      end else if (s_tvalid[md_grant] && m_tready && s_tlast[md_grant]) begin
        nx_locked = 1'b0;
        nx_last   = md_grant;
        nx_cnt    = md_cnt + 16'd1;
      end
      hs = s_tvalid & s_tready;
      if (m_tvalid && m_tready)
        out_log.push_back('{tid: int'(m_tid), data: m_tdata, last: m_tlast, cyc: cyc});
    end
  end

  // Requester side: pop on handshake, then present the next beat of each port.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    #2;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0 && !src_hold[p]) begin
        s_tvalid[p]          = 1'b1;
        s_tlast[p]           = src_q[p][0].last;
        s_tdata[p*DW +: DW]  = src_q[p][0].data;
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tlast[p]           = 1'b0;
        s_tdata[p*DW +: DW]  = '0;
      end
    end
  end

  task automatic send(input int port, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++)
      src_q[port].push_back('{last: (i == n - 1), data: base + DW'(i)});
  endtask

  function automatic bit busy();
    busy = md_locked;
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) busy = 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_done", busy(), 0);
    tick(2);
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    src_hold = '0;
    tick(2);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    resetn   = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    tick(2);
    resetn = 1'b1;

    // Port 2 sends A,B,C.
    out_log.delete();
    send(2, 3, 32'hA);
    drain(50);
    check("t1_beats", out_log.size(), 3);
    if (out_log.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check("t1_data", out_log[i].data, 32'hA + i);
        check("t1_tid", out_log[i].tid, 2);
        check("t1_last", out_log[i].last, i == 2);
      end
    check("t1_pkt_count", pkt_count, 1);

    // All ports continuously requesting one-beat packets after reset.
    reset_pulse();
    out_log.delete();
    for (int p = 0; p < NP; p++) begin
      send(p, 1, 32'h100 * p);
      send(p, 1, 32'h100 * p + 32'h10);
    end
    drain(100);
    check("t2_beats", out_log.size(), 8);
    if (out_log.size() == 8) begin
      for (int i = 0; i < 5; i++) check("t2_order", out_log[i].tid, exp_order[i]);
      for (int i = 0; i < 7; i++) check("t2_gap", out_log[i+1].cyc - out_log[i].cyc, 2);
    end
    check("t2_pkt_count", pkt_count, 8);

    // Port 1 must wait for the whole port 0 packet.
    out_log.delete();
    send(0, 4, 32'h300);
    tick(2);
    send(1, 1, 32'h400);
    for (int i = 0; i < 20 && src_q[0].size() > 0; i++) begin
      @(negedge clk);
      if (src_q[0].size() > 0) check("t3_p1_blocked", s_tready[1], 0);
      @(posedge clk);
      #1;
    end
    drain(40);
    check("t3_beats", out_log.size(), 5);
    if (out_log.size() == 5) begin
      for (int i = 0; i < 4; i++) check("t3_p0_data", out_log[i].data, 32'h300 + i);
      check("t3_p1_tid", out_log[4].tid, 1);
    end

    // Backpressure toggling plus a source bubble inside a 6-beat packet.
    out_log.delete();
    send(3, 6, 32'h500);
    for (int i = 0; i < 60 && busy(); i++) begin
      tick(1);
      m_tready    = ~m_tready;
      src_hold[3] = (i == 4 || i == 5);
    end
    m_tready = 1'b1;
    src_hold = '0;
    drain(40);
    check("t4_beats", out_log.size(), 6);
    if (out_log.size() == 6)
      for (int i = 0; i < 6; i++) begin
        check("t4_data", out_log[i].data, 32'h500 + i);
        check("t4_last", out_log[i].last, i == 5);
      end

    // Reset after beat 2 of 5 discards the rest.
    out_log.delete();
    send(1, 5, 32'h600);
    for (int i = 0; i < 20 && out_log.size() < 2; i++) tick(1);
    check("t5_pre_beats", out_log.size(), 2);
    resetn = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    #1;
    check("t5_imm_m_tvalid", m_tvalid, 0);
    check("t5_imm_m_tdata", m_tdata, 0);
    check("t5_imm_pkt_count", pkt_count, 0);
    tick(2);
    resetn = 1'b1;
    tick(5);
    check("t5_no_more_beats", out_log.size(), 2);
    out_log.delete();
    for (int p = 0; p < NP; p++) send(p, 1, 32'h700 + p);
    drain(60);
    check("t5_beats", out_log.size(), 4);
    if (out_log.size() > 0) check("t5_first_tid", out_log[0].tid, 0);
    check("t5_pkt_count", pkt_count, 4);

    // Counter wrap from a preloaded value.
    dut.pkt_q = 16'hFFFE;
    md_cnt    = 16'hFFFE;
    nx_cnt    = 16'hFFFE;
    tick(1);
    check("t6_preload", pkt_count, 16'hFFFE);
    send(2, 1, 32'h800);
    send(2, 1, 32'h801);
    drain(40);
    check("t6_wrap", pkt_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
